ratio_sin_engine: RTL and testbench

//  Computes y = (a / (a+b+c)) * sin(theta) in fixed point with full valid/ready handshakes.

---
 rtl/ratio_sin_engine_pkg.sv | 22 ++
 rtl/ratio_sin_engine_if.sv | 30 +++
 rtl/ratio_sin_engine_iter_divider.sv | 95 +++++++++
 rtl/ratio_sin_engine.sv | 138 +++++++++++++
 tb/tb_ratio_sin_engine.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/ratio_sin_engine_pkg.sv
// Shared widths and FSM encoding for the ratio*sine engine.
// Quotient width and divisor width derive from the operand and fraction widths.
package ratio_sin_engine_pkg;

  localparam int DW   = 12;
  localparam int FRAC = 14;
  localparam int AW   = 10;
  localparam int SW   = 14;
  localparam int QW   = DW + FRAC;
  localparam int DIVW = DW + 2;
  localparam int YW   = QW + SW;
  localparam int CW   = $clog2(AW + 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_ANG = 3'd1,
    ST_DIV      = 3'd2,
    ST_MUL      = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

endpackage

// File: rtl/ratio_sin_engine_if.sv
// Operand, serial-angle, sine-table and result signals of the engine.
// The engine uses the slave view; the surrounding system uses the master view.
interface ratio_sin_engine_if;
  import ratio_sin_engine_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic [DW-1:0] c;
  logic          ang_valid;
  logic          ang_bit;
  logic [AW-1:0] sin_addr;
  logic [SW-1:0] sin_data;
  logic          out_valid;
  logic          out_ready;
  logic [YW-1:0] y;
  logic          div_zero;

  modport slave (
    input  in_valid, a, b, c, ang_valid, ang_bit, sin_data, out_ready,
    output in_ready, sin_addr, out_valid, y, div_zero
  );

  modport master (
    output in_valid, a, b, c, ang_valid, ang_bit, sin_data, out_ready,
    input  in_ready, sin_addr, out_valid, y, div_zero
  );

endinterface

// File: rtl/ratio_sin_engine_iter_divider.sv
// Restoring divider producing one quotient bit per cycle, MSB first.
// A zero divisor reports dz and forces the quotient to all ones with unchanged latency.
module iter_divider
  import ratio_sin_engine_pkg::*;
#(
  parameter int NW  = QW,
  parameter int DVW = DIVW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [NW-1:0]  dividend,
  input  logic [DVW-1:0] divisor,
  output logic           busy,
  output logic           done,
  output logic [NW-1:0]  quotient,
  output logic           dz
);

  localparam int CNTW = $clog2(NW);

  logic [DVW-1:0]  rem_q, rem_d;
  logic [DVW-1:0]  dvs_q, dvs_d;
  logic [NW-1:0]   dvd_q, dvd_d;
  logic [NW-1:0]   quo_q, quo_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            dz_q, dz_d;
  logic [DVW:0]    trial;
  logic [DVW:0]    diff;
  logic            fits;

  always_comb begin
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    dvd_d  = dvd_q;
    quo_d  = quo_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    dz_d   = dz_q;
    done_d = 1'b0;
    trial  = {rem_q, dvd_q[NW-1]};
    diff   = trial - {1'b0, dvs_q};
    fits   = (trial >= {1'b0, dvs_q});

    if (start) begin
      rem_d  = '0;
      dvs_d  = divisor;
      dvd_d  = dividend;
      quo_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
      dz_d   = (divisor == '0);
    end else if (busy_q) begin
      // A fitting trial leaves a remainder below the divisor, so the top bit drops safely.
      rem_d = fits ? diff[DVW-1:0] : trial[DVW-1:0];
      dvd_d = {dvd_q[NW-2:0], 1'b0};
      quo_d = {quo_q[NW-2:0], fits};
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNTW'(NW - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      dvs_q  <= '0;
      dvd_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      dvd_q  <= dvd_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      dz_q   <= dz_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign dz       = dz_q;
  assign quotient = dz_q ? '1 : quo_q;

endmodule

// File: rtl/ratio_sin_engine.sv
// Computes y = (a/(a+b+c)) * sin(theta): latches operands, assembles the serial angle,
// runs the iterative divide, then registers quotient*sin_data until the consumer takes it.
module ratio_sin_engine
  import ratio_sin_engine_pkg::*;
(
  input logic               clk,
  input logic               rst,
  ratio_sin_engine_if.slave bus
);

  state_e          state_q, state_d;
  logic [AW-1:0]   ang_q, ang_d;
  logic [CW-1:0]   ang_cnt_q, ang_cnt_d;
  logic [DW-1:0]   a_q, a_d;
  logic [DIVW-1:0] sum_q, sum_d;
  logic [YW-1:0]   y_q, y_d;
  logic            dz_q, dz_d;

  logic            hs;
  logic            ang_take;
  logic            ang_done;
  logic [DIVW-1:0] in_sum;
  logic [DW-1:0]   div_a;
  logic [DIVW-1:0] div_dvs;
  logic            div_start;
  logic            div_busy;
  logic            div_done;
  logic            div_dz;
  logic [QW-1:0]   div_quo;

  assign bus.in_ready  = (state_q == ST_IDLE) && !rst;
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.y         = y_q;
  assign bus.div_zero  = dz_q;
  assign bus.sin_addr  = ang_q;

  assign hs       = bus.in_valid && bus.in_ready;
  assign in_sum   = DIVW'(bus.a) + DIVW'(bus.b) + DIVW'(bus.c);
  assign ang_take = ((state_q == ST_IDLE) || (state_q == ST_WAIT_ANG)) && bus.ang_valid
                    && (ang_cnt_q != CW'(AW));
  assign ang_done = (ang_cnt_q == CW'(AW)) || (ang_take && (ang_cnt_q == CW'(AW - 1)));

  // Starting in the handshake cycle uses the live operands; later starts use the latched copy.
  assign div_a   = (state_q == ST_IDLE) ? bus.a  : a_q;
  assign div_dvs = (state_q == ST_IDLE) ? in_sum : sum_q;

  iter_divider #(
    .NW  (QW),
    .DVW (DIVW)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend ({div_a, {FRAC{1'b0}}}),
    .divisor  (div_dvs),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo),
    .dz       (div_dz)
  );

  always_comb begin
    state_d   = state_q;
    ang_d     = ang_q;
    ang_cnt_d = ang_cnt_q;
    a_d       = a_q;
    sum_d     = sum_q;
    y_d       = y_q;
    dz_d      = dz_q;
    div_start = 1'b0;

    if (ang_take) begin
      ang_d     = {ang_q[AW-2:0], bus.ang_bit};
      ang_cnt_d = ang_cnt_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (hs) begin
          a_d   = bus.a;
          sum_d = in_sum;
          if (ang_done) begin
            state_d   = ST_DIV;
            div_start = 1'b1;
          end else begin
            state_d = ST_WAIT_ANG;
          end
        end
      end
      ST_WAIT_ANG: begin
        if (ang_done) begin
          state_d   = ST_DIV;
          div_start = 1'b1;
        end
      end
      ST_DIV: begin
        if (div_done && !div_busy) begin
          state_d = ST_MUL;
        end
      end
      ST_MUL: begin
        y_d     = YW'(div_quo) * YW'(bus.sin_data);
        dz_d    = div_dz;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          ang_cnt_d = '0;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ang_q     <= '0;
      ang_cnt_q <= '0;
      a_q       <= '0;
      sum_q     <= '0;
      y_q       <= '0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      ang_q     <= ang_d;
      ang_cnt_q <= ang_cnt_d;
      a_q       <= a_d;
      sum_q     <= sum_d;
      y_q       <= y_d;
      dz_q      <= dz_d;
    end
  end

endmodule

// File: tb/tb_ratio_sin_engine.sv
// Directed and randomized transactions checked against a plain-arithmetic model of
// y = floor((a<<FRAC)/(a+b+c)) * sin, with an all-ones quotient when the divisor is zero.
module tb_ratio_sin_engine;
  import ratio_sin_engine_pkg::*;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  bit   sin_force;
  logic [SW-1:0] sin_val;

  int   since;
  logic [DW-1:0] ra, rb, rc;
  logic [AW-1:0] rang;

  ratio_sin_engine_if bus_if ();

  ratio_sin_engine dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [SW-1:0] sin_tab(input logic [AW-1:0] addr);
    sin_tab = SW'((32'(addr) * 32'd997 + 32'd123) % 32'd16384);
  endfunction

  // Stand-in for the external sine ROM: combinational from the address.
  always_comb bus_if.sin_data = sin_force ? sin_val : sin_tab(bus_if.sin_addr);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.in_valid  = 1'b0;
    bus_if.ang_valid = 1'b0;
    bus_if.ang_bit   = 1'($urandom);
    bus_if.a         = DW'($urandom);
    bus_if.b         = DW'($urandom);
    bus_if.c         = DW'($urandom);
  endtask

  // Drives the operand handshake and the AW angle bits with independent start offsets;
  // returns how many edges have passed since the later of the two completing edges.
  task automatic send_txn(input logic [DW-1:0] ta, input logic [DW-1:0] tb_v,
                          input logic [DW-1:0] tc, input logic [AW-1:0] tang,
                          input int ang_off, input int op_off, input bit gaps,
                          output int since_later);
    int cyc, hs_cyc, last_bit, bit_idx;
    bit fire, took_bit;
    cyc = 0; hs_cyc = -1; last_bit = -1; bit_idx = 0;
    while ((hs_cyc < 0 || bit_idx < AW) && cyc < 200) begin
      bus_if.ang_valid = (cyc >= ang_off) && (bit_idx < AW) && (!gaps || ($urandom_range(0, 3) != 0));
      if (bus_if.ang_valid) bus_if.ang_bit = tang[AW-1-bit_idx];
      else                  bus_if.ang_bit = 1'($urandom);
      bus_if.in_valid = (cyc >= op_off) && (hs_cyc < 0);
      if (bus_if.in_valid) begin
        bus_if.a = ta; bus_if.b = tb_v; bus_if.c = tc;
      end else begin
        bus_if.a = DW'($urandom); bus_if.b = DW'($urandom); bus_if.c = DW'($urandom);
      end
      fire     = bus_if.in_valid && bus_if.in_ready;
      took_bit = bus_if.ang_valid;
      tick();
      if (fire) hs_cyc = cyc;
      if (took_bit) begin
        if (bit_idx == AW - 1) last_bit = cyc;
        bit_idx++;
      end
      cyc++;
    end
    check("send_complete", {63'd0, (hs_cyc >= 0) && (bit_idx == AW)}, 64'd1);
    idle_inputs();
    since_later = (cyc - 1) - ((hs_cyc > last_bit) ? hs_cyc : last_bit);
  endtask

  // Waits for the result, checks latency and value, holds it for a while, then takes it.
  task automatic collect_txn(input logic [DW-1:0] ta, input logic [DW-1:0] tb_v,
                             input logic [DW-1:0] tc, input logic [AW-1:0] tang,
                             input int since_later, input int hold, input bit extra_bits,
                             input string tag);
    logic [63:0] sum, q, s, ey, edz;
    int n;
    sum = 64'(ta) + 64'(tb_v) + 64'(tc);
    s   = sin_force ? 64'(sin_val) : 64'(sin_tab(tang));
    q   = (sum == 0) ? ((64'd1 << QW) - 1) : ((64'(ta) << FRAC) / sum);
    ey  = q * s;
    edz = (sum == 0) ? 64'd1 : 64'd0;
    n   = since_later;
    while (!bus_if.out_valid && n < QW + 12) begin
      tick();
      n++;
    end
    check({tag, ".latency"},  64'(n), 64'(QW + 2));
    check({tag, ".y"},        64'(bus_if.y), ey);
    check({tag, ".div_zero"}, 64'(bus_if.div_zero), edz);
    check({tag, ".sin_addr"}, 64'(bus_if.sin_addr), 64'(tang));
    check({tag, ".in_ready"}, 64'(bus_if.in_ready), 64'd0);
    for (int h = 0; h < hold; h++) begin
      bus_if.out_ready = 1'b0;
      bus_if.ang_valid = extra_bits;
      bus_if.ang_bit   = 1'($urandom);
      tick();
      check({tag, ".hold_valid"}, 64'(bus_if.out_valid), 64'd1);
      check({tag, ".hold_y"},     64'(bus_if.y), ey);
      check({tag, ".hold_dz"},    64'(bus_if.div_zero), edz);
      check({tag, ".hold_addr"},  64'(bus_if.sin_addr), 64'(tang));
      check({tag, ".hold_rdy"},   64'(bus_if.in_ready), 64'd0);
    end
    bus_if.ang_valid = 1'b0;
    bus_if.out_ready = 1'b1;
    tick();
    bus_if.out_ready = 1'b0;
    check({tag, ".taken_valid"}, 64'(bus_if.out_valid), 64'd0);
    check({tag, ".taken_rdy"},   64'(bus_if.in_ready), 64'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".in_ready"},  64'(bus_if.in_ready), 64'd1);
    check({tag, ".out_valid"}, 64'(bus_if.out_valid), 64'd0);
    check({tag, ".y"},         64'(bus_if.y), 64'd0);
    check({tag, ".div_zero"},  64'(bus_if.div_zero), 64'd0);
    check({tag, ".sin_addr"},  64'(bus_if.sin_addr), 64'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    sin_force   = 1'b0;
    sin_val     = '0;
    bus_if.out_ready = 1'b0;
    idle_inputs();
    rst = 1'b1;
    #1;
    check("rst.in_ready_low", 64'(bus_if.in_ready), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_reset_values("rst");

    // Angle streamed alongside the operands.
    sin_force = 1'b1; sin_val = 14'd8192;
    send_txn(12'd1000, 12'd1000, 12'd1000, 10'h155, 0, 0, 1'b0, since);
    collect_txn(12'd1000, 12'd1000, 12'd1000, 10'h155, since, 0, 1'b0, "t1");
    check("t1.y_const", 64'(bus_if.y), 64'd44736512);

    // Operands first, then angle: the engine waits for the angle.
    sin_val = 14'd16383;
    send_txn(12'd4095, 12'd0, 12'd0, 10'h2C3, 4, 0, 1'b0, since);
    collect_txn(12'd4095, 12'd0, 12'd0, 10'h2C3, since, 1, 1'b0, "t2");
    check("t2.y_const", 64'(bus_if.y), 64'd268419072);

    // Zero divisor, with the last angle bit on the handshake edge.
    sin_val = 14'd3;
    send_txn(12'd0, 12'd0, 12'd0, 10'h3FF, 0, 9, 1'b0, since);
    collect_txn(12'd0, 12'd0, 12'd0, 10'h3FF, since, 0, 1'b0, "t3");
    check("t3.y_const", 64'(bus_if.y), 64'd201326589);

    // Whole angle first, operands three cycles after the last bit.
    sin_force = 1'b0;
    send_txn(12'd1234, 12'd567, 12'd89, 10'h0A7, 0, 12, 1'b0, since);
    collect_txn(12'd1234, 12'd567, 12'd89, 10'h0A7, since, 0, 1'b0, "t4");

    // Consumer stalls five cycles while stray angle bits arrive.
    send_txn(12'd2000, 12'd100, 12'd3000, 10'h1E2, 2, 1, 1'b0, since);
    collect_txn(12'd2000, 12'd100, 12'd3000, 10'h1E2, since, 5, 1'b1, "t5");

    // Reset ten cycles into the divide while angle bits keep arriving.
    send_txn(12'd300, 12'd200, 12'd100, 10'h2AB, 0, 0, 1'b0, since);
    repeat (10) begin
      bus_if.ang_valid = 1'b1;
      bus_if.ang_bit   = 1'($urandom);
      tick();
    end
    bus_if.ang_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("t6.rst_in_ready_low", 64'(bus_if.in_ready), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    check_reset_values("t6.mid_div");

    // Partial angle pending in IDLE, then reset, then a fresh transaction.
    for (int i = 0; i < 4; i++) begin
      bus_if.ang_valid = 1'b1;
      bus_if.ang_bit   = 1'($urandom);
      tick();
    end
    bus_if.ang_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_reset_values("t6.partial");
    send_txn(12'd777, 12'd333, 12'd3000, 10'h19C, 2, 0, 1'b0, since);
    collect_txn(12'd777, 12'd333, 12'd3000, 10'h19C, since, 0, 1'b0, "t6.fresh");

    // Randomized transactions with gappy angle streams and random alignment.
    for (int t = 0; t < 12; t++) begin
      ra   = DW'($urandom);
      rb   = DW'($urandom);
      rc   = DW'($urandom);
      rang = AW'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        ra = '0; rb = '0; rc = '0;
      end else if ($urandom_range(0, 4) == 0) begin
        rb = '0; rc = '0;
      end
      send_txn(ra, rb, rc, rang, $urandom_range(0, 12), $urandom_range(0, 14), 1'b1, since);
      collect_txn(ra, rb, rc, rang, since, $urandom_range(0, 3), 1'($urandom), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
